// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//
// Contents:
//   state_t    - sequencer FSM encoding (also driven out on the debug port)
//   COUNT_W    - width of the saturating event counters
//   COUNT_SAT  - saturation value of those counters
//   cnt_max()  - largest of four cycle parameters
//   cnt_width()- counter width needed for a given cycle parameter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int         COUNT_W   = 8;
  localparam logic [7:0] COUNT_SAT = 8'hFF;

  // Largest of the cycle parameters; sizes the shared cycle counter.
  function automatic int cnt_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // $clog2 of the cycle count; the counter only ever reaches max_val-1,
  // so $clog2 bits suffice. Never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val > 1) return $clog2(max_val);
    return 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for level signals crossing into clk.
//
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-low reset; both stages clear to 0
//   d    - asynchronous input bits (each bit synchronized independently)
//   q    - synchronized output, two clk edges behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the PLL clock tree.
//
// Runs on the board reference clock. Holds the PLL in reset for a fixed
// window, waits for the synchronized lock to stay high for STABLE_CYCLES,
// then releases the downstream domain resets one at a time, bit 0 first,
// STAGGER_CYCLES apart. Loss of lock after release pulls every domain back
// into reset and re-waits for lock; a lock that never arrives restarts the
// PLL after LOCK_TIMEOUT cycles. A one-cycle restart request re-runs the
// whole sequence and beats every other transition in its cycle.
//
// Ports:
//   clk           - reference clock
//   rst           - asynchronous active-low reset
//   lock          - PLL lock, asynchronous to clk
//   restart       - synchronous one-cycle request to re-run the sequence
//   pll_rst_n     - active-low PLL reset (registered)
//   rst_out_n     - active-low domain resets, bit 0 released first (registered)
//   ready         - all domains released and lock good (registered)
//   lost_count    - lock-loss events after release, saturating at 255
//   timeout_count - PLL restarts caused by lock timeout, saturating at 255
//   state         - current FSM state, for debug
//
// ready is a plain status level, not a handshake: it is high exactly while
// every domain reset is released and the sequencer sits in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_RST        = 2,
  parameter int PLL_RST_CYCLES = 32,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lock,
  input  logic               restart,
  output logic               pll_rst_n,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               ready,
  output logic [7:0]         lost_count,
  output logic [7:0]         timeout_count,
  output logic [2:0]         state
);

  localparam int CNT_W = cnt_width(cnt_max(PLL_RST_CYCLES, STABLE_CYCLES,
                                           STAGGER_CYCLES, LOCK_TIMEOUT));
  localparam int IDX_W = cnt_width(NUM_RST);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RST - 1);

  // ---------------------------------------------------------------------
  // Lock synchronizer: only lock_s is ever looked at.
  // ---------------------------------------------------------------------
  logic lock_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock),
    .q   (lock_s)
  );

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;

  logic               pll_rst_n_nx;
  logic [NUM_RST-1:0] rst_out_n_nx;
  logic               ready_nx;
  logic [7:0]         lost_count_nx;
  logic [7:0]         timeout_count_nx;

  // One-cycle events from the next-state logic that the output logic acts on.
  logic pll_go_ev;    // PLL reset window finished
  logic timeout_ev;   // lock never came, restart the PLL
  logic loss_ev;      // lock dropped after release began
  logic release_ev;   // release rst_out_n[idx_q] this edge
  logic last_ev;      // the release this edge is the final one
  logic bad_state;    // unreachable encoding, recover to reset values

  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment: cnt never exceeds its terminal value in practice,
  // but it must never wrap even if a state were entered unexpectedly.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // ---------------------------------------------------------------------
  // Process 1: state register and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      idx_q         <= '0;
      pll_rst_n     <= 1'b0;
      rst_out_n     <= '0;
      ready         <= 1'b0;
      lost_count    <= '0;
      timeout_count <= '0;
    end else begin
      state_q       <= state_nx;
      cnt_q         <= cnt_nx;
      idx_q         <= idx_nx;
      pll_rst_n     <= pll_rst_n_nx;
      rst_out_n     <= rst_out_n_nx;
      ready         <= ready_nx;
      lost_count    <= lost_count_nx;
      timeout_count <= timeout_count_nx;
    end
  end

  assign state = state_q;

  // ---------------------------------------------------------------------
  // Process 2: next-state, cycle counter and release index
  // Priority inside a cycle: restart > lock loss > timer expiry.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    idx_nx     = idx_q;
    pll_go_ev  = 1'b0;
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    release_ev = 1'b0;
    last_ev    = 1'b0;
    bad_state  = 1'b0;

    if (restart) begin
      state_nx = PLL_RST;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          // lock_s is meaningless while the PLL is held in reset.
          if (cnt_q == PLL_RST_LAST) begin
            state_nx  = WAIT_LOCK;
            cnt_nx    = '0;
            pll_go_ev = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_nx   = PLL_RST;
            cnt_nx     = '0;
            timeout_ev = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end

        STABLE: begin
          // A drop here is just an unsettled lock, not a loss event:
          // nothing has been released yet.
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_nx = RELEASE;
            cnt_nx   = '0;
            idx_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end

        RELEASE: begin
          // Loss is checked first so a bit can never rise with lock_s low.
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
            idx_nx   = '0;
            loss_ev  = 1'b1;
          end else if (cnt_q == STAGGER_LAST) begin
            cnt_nx     = '0;
            release_ev = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_nx = RUN;
              last_ev  = 1'b1;
            end else begin
              idx_nx = idx_q + 1'b1;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
            idx_nx   = '0;
            loss_ev  = 1'b1;
          end
        end

        default: begin
          state_nx  = PLL_RST;
          cnt_nx    = '0;
          idx_nx    = '0;
          bad_state = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Process 3: next values of the registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    pll_rst_n_nx     = pll_rst_n;
    rst_out_n_nx     = rst_out_n;
    ready_nx         = ready;
    lost_count_nx    = lost_count;
    timeout_count_nx = timeout_count;

    if (restart || bad_state) begin
      // Counters deliberately untouched: a restart is not an event.
      pll_rst_n_nx = 1'b0;
      rst_out_n_nx = '0;
      ready_nx     = 1'b0;
    end else begin
      if (pll_go_ev) begin
        pll_rst_n_nx = 1'b1;
      end

      if (timeout_ev) begin
        pll_rst_n_nx = 1'b0;
        if (timeout_count != COUNT_SAT) begin
          timeout_count_nx = timeout_count + 8'd1;
        end
      end

      // The PLL stays running on a loss; only its consumers go back
      // into reset while the lock recovers.
      if (loss_ev) begin
        rst_out_n_nx = '0;
        ready_nx     = 1'b0;
        if (lost_count != COUNT_SAT) begin
          lost_count_nx = lost_count + 8'd1;
        end
      end

      // Compare-and-set per bit keeps the select in range for any NUM_RST.
      if (release_ev) begin
        for (int i = 0; i < NUM_RST; i++) begin
          if (idx_q == IDX_W'(i)) begin
            rst_out_n_nx[i] = 1'b1;
          end
        end
      end

      if (last_ev) begin
        ready_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
// Edge numbering: edge 1 is the first rising clk edge after rst is released.
// Outputs are sampled 1 time unit after the rising edge; inputs change there too.
module tb_pll_reset_sequencer;

  localparam int NUM_RST        = 2;
  localparam int PLL_RST_CYCLES = 3;
  localparam int STABLE_CYCLES  = 8;
  localparam int STAGGER_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 20;

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               lock;
  logic               restart;
  logic               pll_rst_n;
  logic [NUM_RST-1:0] rst_out_n;
  logic               ready;
  logic [7:0]         lost_count;
  logic [7:0]         timeout_count;
  logic [2:0]         state;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_RST        (NUM_RST),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lock          (lock),
    .restart       (restart),
    .pll_rst_n     (pll_rst_n),
    .rst_out_n     (rst_out_n),
    .ready         (ready),
    .lost_count    (lost_count),
    .timeout_count (timeout_count),
    .state         (state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int edge_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset(input logic lock_init);
    rst     = 1'b0;
    restart = 1'b0;
    lock    = lock_init;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
  endtask

  // Bounded wait for a given debug state; an expired budget is a miscompare.
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      step_to(edge_n + 1);
      n++;
    end
    if (state !== s) check_val(tag, 32'(state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // ===== reset state, then normal bring-up with lock high from time 0 =====
    rst     = 1'b0;
    restart = 1'b0;
    lock    = 1'b1;
    #1;
    check_val("rst_state",     32'(state),         32'(S_PLL_RST));
    check_val("rst_pll_rst_n", 32'(pll_rst_n),     32'd0);
    check_val("rst_rst_out_n", 32'(rst_out_n),     32'd0);
    check_val("rst_ready",     32'(ready),         32'd0);
    check_val("rst_lost",      32'(lost_count),    32'd0);
    check_val("rst_timeout",   32'(timeout_count), 32'd0);
    do_reset(1'b1);

    step_to(2);  check_val("up_pll_e2",   32'(pll_rst_n), 32'd0);
    step_to(3);  check_val("up_pll_e3",   32'(pll_rst_n), 32'd1);
                 check_val("up_state_e3", 32'(state),     32'(S_WAIT_LOCK));
    step_to(4);  check_val("up_state_e4", 32'(state),     32'(S_STABLE));
    step_to(12); check_val("up_state_e12",32'(state),     32'(S_RELEASE));
    step_to(15); check_val("up_rst_e15",  32'(rst_out_n), 32'b00);
    step_to(16); check_val("up_rst_e16",  32'(rst_out_n), 32'b01);
                 check_val("up_rdy_e16",  32'(ready),     32'd0);
    step_to(19); check_val("up_rst_e19",  32'(rst_out_n), 32'b01);
    step_to(20); check_val("up_rst_e20",  32'(rst_out_n), 32'b11);
                 check_val("up_rdy_e20",  32'(ready),     32'd1);
                 check_val("up_state_e20",32'(state),     32'(S_RUN));

    // ===== lock loss in RUN: lock sampled low at edge 30 =====
    step_to(29); lock = 1'b0;
    step_to(31); check_val("loss_rst_e31",  32'(rst_out_n),  32'b11);
                 check_val("loss_rdy_e31",  32'(ready),      32'd1);
    step_to(32); check_val("loss_rst_e32",  32'(rst_out_n),  32'b00);
                 check_val("loss_rdy_e32",  32'(ready),      32'd0);
                 check_val("loss_cnt_e32",  32'(lost_count), 32'd1);
                 check_val("loss_state_e32",32'(state),      32'(S_WAIT_LOCK));
                 check_val("loss_pll_e32",  32'(pll_rst_n),  32'd1);
    step_to(33); lock = 1'b1;   // sampled at 34, lock_s at 35, STABLE at 36
    step_to(36); check_val("rel2_state_e36",32'(state),      32'(S_STABLE));
    step_to(47); check_val("rel2_rst_e47",  32'(rst_out_n),  32'b00);
    step_to(48); check_val("rel2_rst_e48",  32'(rst_out_n),  32'b01);
    step_to(51); check_val("rel2_rst_e51",  32'(rst_out_n),  32'b01);
    step_to(52); check_val("rel2_rst_e52",  32'(rst_out_n),  32'b11);
                 check_val("rel2_rdy_e52",  32'(ready),      32'd1);
                 check_val("rel2_lost_e52", 32'(lost_count), 32'd1);

    // ===== asynchronous reset mid-cycle forces reset values at once =====
    step_to(55);
    #2 rst = 1'b0;
    #1;
    check_val("arst_state", 32'(state),      32'(S_PLL_RST));
    check_val("arst_pll",   32'(pll_rst_n),  32'd0);
    check_val("arst_rst",   32'(rst_out_n),  32'd0);
    check_val("arst_rdy",   32'(ready),      32'd0);
    check_val("arst_lost",  32'(lost_count), 32'd0);

    // ===== lock never arrives: PLL restarted every 23 edges =====
    do_reset(1'b0);
    step_to(3);  check_val("to_pll_e3",   32'(pll_rst_n),     32'd1);
    step_to(22); check_val("to_pll_e22",  32'(pll_rst_n),     32'd1);
                 check_val("to_cnt_e22",  32'(timeout_count), 32'd0);
    step_to(23); check_val("to_pll_e23",  32'(pll_rst_n),     32'd0);
                 check_val("to_cnt_e23",  32'(timeout_count), 32'd1);
                 check_val("to_state_e23",32'(state),         32'(S_PLL_RST));
    step_to(26); check_val("to_pll_e26",  32'(pll_rst_n),     32'd1);
    step_to(45); check_val("to_pll_e45",  32'(pll_rst_n),     32'd1);
    step_to(46); check_val("to_pll_e46",  32'(pll_rst_n),     32'd0);
                 check_val("to_cnt_e46",  32'(timeout_count), 32'd2);
                 check_val("to_rst_e46",  32'(rst_out_n),     32'd0);
                 check_val("to_lost_e46", 32'(lost_count),    32'd0);

    // ===== one-cycle lock glitch during STABLE =====
    do_reset(1'b1);
    step_to(5);  lock = 1'b0;   // sampled low at edge 6
    step_to(6);  lock = 1'b1;   // lock_s low only after edge 7
    step_to(7);  check_val("gl_state_e7", 32'(state),      32'(S_STABLE));
    step_to(8);  check_val("gl_state_e8", 32'(state),      32'(S_WAIT_LOCK));
                 check_val("gl_lost_e8",  32'(lost_count), 32'd0);
    step_to(9);  check_val("gl_state_e9", 32'(state),      32'(S_STABLE));
    step_to(20); check_val("gl_rst_e20",  32'(rst_out_n),  32'b00);
    step_to(21); check_val("gl_rst_e21",  32'(rst_out_n),  32'b01);
    step_to(24); check_val("gl_rst_e24",  32'(rst_out_n),  32'b01);
    step_to(25); check_val("gl_rst_e25",  32'(rst_out_n),  32'b11);
                 check_val("gl_rdy_e25",  32'(ready),      32'd1);
                 check_val("gl_lost_e25", 32'(lost_count), 32'd0);

    // ===== restart in the same cycle lock_s falls in RUN =====
    do_reset(1'b1);
    step_to(24); check_val("rs_state_e24", 32'(state), 32'(S_RUN));
                 lock = 1'b0;   // sampled at 25, lock_s low after 26
    step_to(26); check_val("rs_rst_e26",   32'(rst_out_n), 32'b11);
                 restart = 1'b1;
    step_to(27); restart = 1'b0;
                 check_val("rs_state_e27", 32'(state),      32'(S_PLL_RST));
                 check_val("rs_pll_e27",   32'(pll_rst_n),  32'd0);
                 check_val("rs_rst_e27",   32'(rst_out_n),  32'd0);
                 check_val("rs_rdy_e27",   32'(ready),      32'd0);
                 check_val("rs_lost_e27",  32'(lost_count), 32'd0);
    step_to(30); check_val("rs_state_e30", 32'(state),      32'(S_WAIT_LOCK));
                 check_val("rs_pll_e30",   32'(pll_rst_n),  32'd1);

    // ===== 300 lock losses: lost_count saturates =====
    do_reset(1'b1);
    for (int i = 1; i <= 300; i++) begin
      lock = 1'b1;
      wait_state(S_RELEASE, 200, "sat_wait_release");
      lock = 1'b0;
      wait_state(S_WAIT_LOCK, 20, "sat_wait_wait_lock");
      if (i == 10)  check_val("sat_lost_10",  32'(lost_count), 32'd10);
      if (i == 255) check_val("sat_lost_255", 32'(lost_count), 32'd255);
    end
    check_val("sat_lost_300", 32'(lost_count),    32'd255);
    check_val("sat_timeout",  32'(timeout_count), 32'd0);
    check_val("sat_rst",      32'(rst_out_n),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
